// File: rtl/nn_stream_feeder_pkg.sv
// Shared definitions for the stream feeder: default frame geometry, the
// controller state encoding, and a pointer-width helper.
package nn_stream_feeder_pkg;

  // Network-wide geometry: sample width and first-layer input count.
  localparam int dataWidth       = 16;
  localparam int numWeightLayer1 = 784;

  // Controller states.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } feeder_state_e;

  // Address width for a buffer of 'depth' entries; never less than one bit.
  function automatic int ptr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/nn_stream_feeder_frame_ram.sv
// Frame buffer for nn_stream_feeder: one write port, one registered read
// port, no reset on the array so it maps onto block RAM.
// Ports:
//   clk              - clock
//   wr_en/addr/data  - write port
//   rd_en/rd_addr    - read request; rd_data updates on the next edge
//   rd_data          - registered read data, holds while rd_en is low
module feeder_frame_ram
  import nn_stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = dataWidth,
  parameter int DEPTH      = numWeightLayer1,
  parameter int ADDR_WIDTH = ptr_width(numWeightLayer1)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; read data holds when not enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/nn_stream_feeder.sv
// Loads one input frame from the host, streams it to the network as an
// AXI-Stream burst on request, then waits (bounded) for the classification.
// Ports:
//   s_axi_aclk, s_axi_aresetn      - clock, async active-low reset
//   soft_reset                      - synchronous abort back to FILL
//   load_data/load_valid/load_ready - host frame load
//   start                           - send the loaded frame (READY only)
//   m_axis_*                        - stream toward the network
//   nn_out/nn_out_valid             - network result and its strobe
//   result/result_valid             - captured result, one-cycle strobe
//   busy                            - SEND or WAIT in progress
//   timeout_err                     - no result in time; sticky until start
module nn_stream_feeder
  import nn_stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = dataWidth,
  parameter int NUM_INPUTS     = numWeightLayer1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  soft_reset,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  input  logic [31:0]           nn_out,
  input  logic                  nn_out_valid,
  output logic [31:0]           result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int PTR_W = ptr_width(NUM_INPUTS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_INPUTS - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO    = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  feeder_state_e    state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             valid_nxt, last_nxt, rv_nxt, terr_nxt;
  logic [31:0]      result_nxt;
  logic             beat_done;
  logic             ram_we, ram_re;
  logic [PTR_W-1:0] ram_raddr;

  // The RAM output register is the stream data register: it only reloads
  // when the current beat is accepted, so data is stable under backpressure.
  feeder_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_INPUTS),
    .ADDR_WIDTH (PTR_W)
  ) u_frame_ram (
    .clk     (s_axi_aclk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (m_axis_data)
  );

  assign load_ready = (state == FILL);
  assign busy       = (state == SEND) || (state == WAIT);
  assign beat_done  = m_axis_valid && m_axis_ready;
  assign cnt_inc    = cnt + CNT_ONE;

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath next values and RAM controls.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    valid_nxt  = m_axis_valid;
    last_nxt   = m_axis_last;
    result_nxt = result;
    rv_nxt     = 1'b0;
    terr_nxt   = timeout_err;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr;

    if (soft_reset) begin
      state_nxt  = FILL;
      wr_ptr_nxt = PTR_ZERO;
      rd_ptr_nxt = PTR_ZERO;
      cnt_nxt    = CNT_ZERO;
      valid_nxt  = 1'b0;
      last_nxt   = 1'b0;
      terr_nxt   = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (load_valid) begin
            ram_we = 1'b1;
            if (wr_ptr == LAST_IDX) begin
              state_nxt = READY;
            end else begin
              wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
          end else begin
            state_nxt = FILL;
          end
        end
        READY: begin
          if (start) begin
            // Fetch beat 0 now so it is on the bus the cycle after start.
            state_nxt  = SEND;
            rd_ptr_nxt = PTR_ZERO;
            ram_re     = 1'b1;
            ram_raddr  = PTR_ZERO;
            valid_nxt  = 1'b1;
            last_nxt   = (LAST_IDX == PTR_ZERO);
            terr_nxt   = 1'b0;
          end else begin
            state_nxt = READY;
          end
        end
        SEND: begin
          if (beat_done) begin
            if (rd_ptr == LAST_IDX) begin
              state_nxt = WAIT;
              valid_nxt = 1'b0;
              last_nxt  = 1'b0;
              cnt_nxt   = CNT_ZERO;
            end else begin
              // Prefetch the following beat into the output register.
              rd_ptr_nxt = rd_ptr + PTR_ONE;
              ram_re     = 1'b1;
              ram_raddr  = rd_ptr + PTR_ONE;
              last_nxt   = ((rd_ptr + PTR_ONE) == LAST_IDX);
            end
          end else begin
            state_nxt = SEND;
          end
        end
        WAIT: begin
          // A result arriving on the timeout cycle takes priority.
          if (nn_out_valid) begin
            result_nxt = nn_out;
            rv_nxt     = 1'b1;
            state_nxt  = FILL;
            wr_ptr_nxt = PTR_ZERO;
            cnt_nxt    = CNT_ZERO;
          end else if (cnt_inc == TIMEOUT_VAL) begin
            terr_nxt   = 1'b1;
            state_nxt  = FILL;
            wr_ptr_nxt = PTR_ZERO;
            cnt_nxt    = CNT_ZERO;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt  = FILL;
          wr_ptr_nxt = PTR_ZERO;
          rd_ptr_nxt = PTR_ZERO;
          valid_nxt  = 1'b0;
          last_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr       <= PTR_ZERO;
      rd_ptr       <= PTR_ZERO;
      cnt          <= CNT_ZERO;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      result       <= 32'd0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      cnt          <= cnt_nxt;
      m_axis_valid <= valid_nxt;
      m_axis_last  <= last_nxt;
      result       <= result_nxt;
      result_valid <= rv_nxt;
      timeout_err  <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_nn_stream_feeder.sv
// Directed bench for nn_stream_feeder with a frame-level reference model.
module tb_nn_stream_feeder;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int TO = 10;

  localparam int LOADING   = 0;
  localparam int ARMED     = 1;
  localparam int STREAMING = 2;
  localparam int AWAITING  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, soft_reset, load_valid, start, m_axis_ready, nn_out_valid;
  logic [DW-1:0] load_data;
  logic [31:0]   nn_out;
  logic          load_ready, m_axis_valid, m_axis_last, result_valid, busy, timeout_err;
  logic [DW-1:0] m_axis_data;
  logic [31:0]   result;

  nn_stream_feeder #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .soft_reset    (soft_reset),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .start         (start),
    .m_axis_data   (m_axis_data),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .m_axis_last   (m_axis_last),
    .nn_out        (nn_out),
    .nn_out_valid  (nn_out_valid),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame contents, phase, beats sent, cycles waited.
  int          ph, cnt, sent, elapsed;
  int          frame [N];
  logic [31:0] m_res;
  logic        m_rv, m_terr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= LOADING; cnt <= 0; sent <= 0; elapsed <= 0;
      m_res <= 32'd0; m_rv <= 1'b0; m_terr <= 1'b0;
    end else begin
      m_rv <= 1'b0;
      if (soft_reset) begin
        ph <= LOADING; cnt <= 0; sent <= 0; elapsed <= 0; m_terr <= 1'b0;
      end else begin
        case (ph)
          LOADING: if (load_valid) begin
            frame[cnt] <= int'(load_data);
            cnt <= cnt + 1;
            if (cnt + 1 == N) ph <= ARMED;
          end
          ARMED: if (start) begin
            ph <= STREAMING; sent <= 0; m_terr <= 1'b0;
          end
          STREAMING: if (m_axis_ready) begin
            if (sent == N - 1) begin ph <= AWAITING; elapsed <= 0; end
            else sent <= sent + 1;
          end
          AWAITING: begin
            if (nn_out_valid) begin
              m_res <= nn_out; m_rv <= 1'b1; ph <= LOADING; cnt <= 0;
            end else if (elapsed + 1 == TO) begin
              m_terr <= 1'b1; ph <= LOADING; cnt <= 0;
            end else begin
              elapsed <= elapsed + 1;
            end
          end
          default: ph <= LOADING;
        endcase
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("load_ready",   load_ready,   ph == LOADING);
    chk("busy",         busy,         (ph == STREAMING) || (ph == AWAITING));
    chk("m_axis_valid", m_axis_valid, ph == STREAMING);
    chk("m_axis_last",  m_axis_last,  (ph == STREAMING) && (sent == N - 1));
    if (ph == STREAMING) chk("m_axis_data", m_axis_data, frame[sent]);
    chk("result",       result,       m_res);
    chk("result_valid", result_valid, m_rv);
    chk("timeout_err",  timeout_err,  m_terr);
  end

  task automatic load_frame(input int base);
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_data  = DW'(base + i);
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; soft_reset = 1'b0; load_valid = 1'b0; load_data = '0;
    start = 1'b0; m_axis_ready = 1'b1; nn_out_valid = 1'b0; nn_out = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", m_axis_valid, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", busy, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("load_ready_after_reset", load_ready, 32'd1);

    // start while filling is ignored
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_in_fill_ignored", busy, 32'd0);

    // basic frame, nn_out_valid during SEND ignored, then result 7
    load_frame(1);
    chk("ready_after_load", load_ready, 32'd0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("t1_beat1", m_axis_data, 32'd1);
    chk("t1_valid", m_axis_valid, 32'd1);
    nn_out = 32'd99; nn_out_valid = 1'b1;
    @(negedge clk); chk("t1_beat2", m_axis_data, 32'd2); chk("t1_last2", m_axis_last, 32'd0);
    @(negedge clk); chk("t1_beat3", m_axis_data, 32'd3);
    @(negedge clk); chk("t1_beat4", m_axis_data, 32'd4); chk("t1_last4", m_axis_last, 32'd1);
    nn_out_valid = 1'b0;
    @(negedge clk); chk("t1_wait_busy", busy, 32'd1); chk("t1_send_nn_ignored", result, 32'd0);
    nn_out = 32'd7; nn_out_valid = 1'b1;
    @(negedge clk); nn_out_valid = 1'b0;
    chk("t1_result", result, 32'd7); chk("t1_rv", result_valid, 32'd1);
    @(negedge clk); chk("t1_rv_pulse", result_valid, 32'd0); chk("t1_fill", load_ready, 32'd1);

    // backpressure on beat 2, then timeout
    load_frame(1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("bp_beat1", m_axis_data, 32'd1);
    @(negedge clk); chk("bp_beat2", m_axis_data, 32'd2);
    m_axis_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_data", m_axis_data, 32'd2);
      chk("bp_hold_valid", m_axis_valid, 32'd1);
    end
    m_axis_ready = 1'b1;
    @(negedge clk); chk("bp_beat3", m_axis_data, 32'd3);
    @(negedge clk); chk("bp_beat4", m_axis_data, 32'd4); chk("bp_last", m_axis_last, 32'd1);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_pending", timeout_err, 32'd0);
      chk("to_busy", busy, 32'd1);
    end
    @(negedge clk);
    chk("to_err", timeout_err, 32'd1); chk("to_fill", load_ready, 32'd1);

    // sticky until start, then result coincident with timeout wins
    load_frame(1);
    chk("to_sticky", timeout_err, 32'd1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("to_cleared_by_start", timeout_err, 32'd0);
    repeat (3) @(negedge clk);
    chk("co_beat4", m_axis_data, 32'd4);
    repeat (TO) @(negedge clk);
    nn_out = 32'd42; nn_out_valid = 1'b1;
    @(negedge clk); nn_out_valid = 1'b0;
    chk("co_result", result, 32'd42); chk("co_rv", result_valid, 32'd1);
    chk("co_no_timeout", timeout_err, 32'd0);

    // soft reset in WAIT keeps result
    load_frame(5);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("sr_in_wait", busy, 32'd1);
    soft_reset = 1'b1; @(negedge clk); soft_reset = 1'b0;
    chk("sr_fill", load_ready, 32'd1); chk("sr_busy", busy, 32'd0);
    chk("sr_result_kept", result, 32'd42);

    // nn_out_valid in FILL ignored
    nn_out = 32'd55; nn_out_valid = 1'b1; @(negedge clk); nn_out_valid = 1'b0;
    chk("fill_nn_ignored", result, 32'd42);

    // new frame after soft reset, async reset mid-SEND
    load_frame(9);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("ar_beat1", m_axis_data, 32'd9);
    @(negedge clk); chk("ar_beat2", m_axis_data, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", m_axis_valid, 32'd0); chk("ar_busy", busy, 32'd0);
    chk("ar_result", result, 32'd0); chk("ar_last", m_axis_last, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("ar_fill", load_ready, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
